// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps a 4-bit pattern through a function unit, captures results into a 16-entry buffer.
// Optional SWEEP_SIGNATURE_EN adds a rotate-XOR signature of captured results on SIG_O.
module truth_table_sweeper #(
   parameter int STEP_CYCLES = 50_000_000
) (
   input  logic       CLOCK_50_I,
   input  logic       resetn,
   input  logic       START_I,
   input  logic       STOP_I,
   input  logic       MODE_I,
   output logic [3:0] PATTERN_O,
   input  logic [8:0] RESULT_I,
   input  logic [3:0] READ_ADDR_I,
   output logic [8:0] READ_DATA_O,
   output logic       BUSY_O,
   output logic       DONE_O,
   output logic [7:0] SWEEP_COUNT_O,
   output logic [8:0] SIG_O
);
   typedef enum logic [2:0] {IDLE, APPLY, CAPTURE, ADVANCE, DONE} state_t;
   localparam logic [25:0] LAST = 26'(STEP_CYCLES - 1);
   state_t      state;
   logic [25:0] cnt;
   logic        start_q;
   logic        armed;
   logic [8:0]  mem [16];
   logic        launch;
   // armed needs one low sample after reset so a START held through release cannot launch
   assign launch = START_I & ~start_q & armed;
   always_ff @(posedge CLOCK_50_I) begin
      if (!resetn) begin
         state         <= IDLE;
         PATTERN_O     <= '0;
         cnt           <= '0;
         BUSY_O        <= 1'b0;
         DONE_O        <= 1'b0;
         SWEEP_COUNT_O <= '0;
         start_q       <= 1'b0;
         armed         <= 1'b0;
      end else begin
         start_q <= START_I;
         if (!START_I) armed <= 1'b1;
         if (STOP_I) begin
            state     <= IDLE;
            PATTERN_O <= '0;
            BUSY_O    <= 1'b0;
            DONE_O    <= 1'b0;
         end else begin
            case (state)
               IDLE, DONE: if (launch) begin
                  state     <= APPLY;
                  PATTERN_O <= '0;
                  cnt       <= '0;
                  BUSY_O    <= 1'b1;
                  DONE_O    <= 1'b0;
               end
               APPLY: begin
                  cnt <= cnt + 26'd1;
                  if (cnt == LAST) state <= CAPTURE;
               end
               CAPTURE: state <= ADVANCE;
               ADVANCE: begin
                  cnt <= '0;
                  if (PATTERN_O != 4'hF) begin
                     PATTERN_O <= PATTERN_O + 4'd1;
                     state     <= APPLY;
                  end else begin
                     SWEEP_COUNT_O <= (SWEEP_COUNT_O == 8'hFF) ? SWEEP_COUNT_O : SWEEP_COUNT_O + 8'd1;
                     if (MODE_I) begin
                        PATTERN_O <= '0;
                        state     <= APPLY;
                     end else begin
                        state  <= DONE;
                        BUSY_O <= 1'b0;
                        DONE_O <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
   always_ff @(posedge CLOCK_50_I) begin
      if (!resetn) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
         READ_DATA_O <= '0;
      end else begin
         READ_DATA_O <= mem[READ_ADDR_I];
         if (state == CAPTURE && !STOP_I) mem[PATTERN_O] <= RESULT_I;
      end
   end
`ifdef SWEEP_SIGNATURE_EN
   logic sig_clr;
   assign sig_clr = !STOP_I && ((launch && (state == IDLE || state == DONE)) ||
                                (state == ADVANCE && PATTERN_O == 4'hF && MODE_I));
   always_ff @(posedge CLOCK_50_I) begin
      if (!resetn || sig_clr) SIG_O <= '0;
      else if (state == CAPTURE && !STOP_I) SIG_O <= {SIG_O[7:0], SIG_O[8]} ^ RESULT_I;
   end
`else
   assign SIG_O = '0;
`endif
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed sequence with randomized function tables against a reference model.
module tb_truth_table_sweeper;
   localparam int S = 2;
   localparam int SWEEP = 16 * (S + 2);
   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       mode = 1'b0;
   logic [3:0] pattern;
   logic [8:0] result;
   logic [3:0] read_addr = '0;
   logic [8:0] read_data;
   logic       busy;
   logic       done;
   logic [7:0] sweep_count;
   logic [8:0] sig;
   logic [8:0] tbl [16];
   int vectors = 0;
   int errors = 0;

   truth_table_sweeper #(.STEP_CYCLES(S)) dut (
      .CLOCK_50_I(clk), .resetn(resetn), .START_I(start), .STOP_I(stop), .MODE_I(mode),
      .PATTERN_O(pattern), .RESULT_I(result), .READ_ADDR_I(read_addr), .READ_DATA_O(read_data),
      .BUSY_O(busy), .DONE_O(done), .SWEEP_COUNT_O(sweep_count), .SIG_O(sig)
   );

   always #5 clk = ~clk;
   assign result = tbl[pattern];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] sig_model();
      logic [8:0] s = '0;
      for (int k = 0; k < 16; k++) s = {s[7:0], s[8]} ^ tbl[k];
`ifdef SWEEP_SIGNATURE_EN
      return s;
`else
      return 9'h0;
`endif
   endfunction

   task automatic randomize_tbl();
      for (int k = 0; k < 16; k++) tbl[k] = 9'($urandom);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
   endtask

   task automatic launch();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_pattern(input logic [3:0] p);
      int n = 0;
      while (pattern !== p && n < 500) begin
         step();
         n++;
      end
      check("wait_pattern", pattern, p);
   endtask

   task automatic read_check(input string tag, input int upto);
      for (int k = 0; k < 16; k++) begin
         read_addr = 4'(k);
         step();
         check(tag, read_data, (k < upto) ? tbl[k] : 9'h0);
      end
   endtask

   initial begin
      int n, wraps, saw_done, c192, c193;
      logic [3:0] prev;
      randomize_tbl();
      step();
      do_reset();
      check("rst_pattern", pattern, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_count", sweep_count, 0);
      check("rst_sig", sig, 0);
      check("rst_rdata", read_data, 0);
      step();

      // single sweep with random function table
      launch();
      n = 0;
      while (busy === 1'b1 && n < 300) begin
         n++;
         step();
      end
      check("busy_cycles", n, SWEEP);
      check("done_after_sweep", done, 1);
      check("count_after_sweep", sweep_count, 1);
      check("pattern_held", pattern, 15);
      check("sig_single", sig, sig_model());
      read_check("read_full", 16);
      check("done_persist", done, 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stop_from_done", done, 0);

      // abort during pattern 6
      do_reset();
      randomize_tbl();
      step();
      launch();
      wait_pattern(4'd6);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stop_pattern", pattern, 0);
      check("stop_busy", busy, 0);
      check("stop_done", done, 0);
      check("stop_count", sweep_count, 0);
      read_check("read_partial", 6);

      // reset mid-sweep at pattern 9 with START held high across release
      launch();
      wait_pattern(4'd9);
      resetn = 1'b0;
      start = 1'b1;
      step();
      resetn = 1'b1;
      check("mrst_pattern", pattern, 0);
      check("mrst_busy", busy, 0);
      check("mrst_done", done, 0);
      check("mrst_count", sweep_count, 0);
      check("mrst_sig", sig, 0);
      check("mrst_rdata", read_data, 0);
      for (int k = 0; k < 5; k++) step();
      check("held_start_no_launch", busy, 0);
      read_check("read_cleared", 0);
      start = 1'b0;
      step();
      start = 1'b1;
      step();
      check("relaunch_after_low", busy, 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      start = 1'b0;
      step();

      // START edge with STOP in the same cycle from IDLE
      start = 1'b1;
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("start_stop_same", busy, 0);
      step();
      check("start_edge_discarded", busy, 0);
      start = 1'b0;

      // continuous mode, constant all-ones result
      do_reset();
      for (int k = 0; k < 16; k++) tbl[k] = 9'h1FF;
      mode = 1'b1;
      step();
      launch();
      wraps = 0;
      saw_done = 0;
      c192 = -1;
      c193 = -1;
      prev = pattern;
      for (int t = 1; t <= 200; t++) begin
         if (prev == 4'd15 && pattern == 4'd0) wraps++;
         if (done === 1'b1) saw_done = 1;
         if (t == 192) c192 = int'(sweep_count);
         if (t == 193) c193 = int'(sweep_count);
         prev = pattern;
         start = (t == 50);
         step();
      end
      start = 1'b0;
      check("cont_wraps", wraps, 3);
      check("cont_no_done", saw_done, 0);
      check("cont_count_192", c192, 2);
      check("cont_count_193", c193, 3);
      for (int k = 0; k < 300 * SWEEP - 200; k++) step();
      check("count_saturate", sweep_count, 255);
      mode = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      check("cont_to_done", done, 1);
      check("cont_busy_low", busy, 0);
      check("count_held", sweep_count, 255);
      check("sig_const", sig, sig_model());
      read_check("read_ones", 16);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 50_000_000, settle cycles per applied pattern (legal range 1..2^26-1).
REQ-002 SHALL have port CLOCK_50_I  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-004 SHALL have port START_I  input  1  level; internal rising-edge detect launches a sweep.
REQ-005 SHALL have port STOP_I  input  1  level; aborts any active sweep.
REQ-006 SHALL have port MODE_I  input  1  0 = single sweep, 1 = continuous; sampled at end of each sweep.
REQ-007 SHALL have port PATTERN_O  output  4  stimulus pattern driven to the boolean function unit.
REQ-008 SHALL have port RESULT_I  input  9  function-unit result for the current PATTERN_O.
REQ-009 SHALL have port READ_ADDR_I  input  4  capture-buffer read address.
REQ-010 SHALL have port READ_DATA_O  output  9  capture-buffer read data.
REQ-011 SHALL have port BUSY_O  output  1  high in APPLY/CAPTURE/ADVANCE.
REQ-012 SHALL have port DONE_O  output  1  high in DONE.
REQ-013 SHALL have port SWEEP_COUNT_O  output  8  completed sweeps, saturating.
REQ-014 SHALL have port SIG_O  output  9  result signature (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, APPLY, CAPTURE, ADVANCE, DONE.
REQ-016 IDLE or DONE + START_I rising edge (START_I=1, previous-cycle START_I=0) -> APPLY next cycle, PATTERN_O=0, settle counter=0.
REQ-017 APPLY SHALL hold PATTERN_O and increment settle counter; at count STEP_CYCLES-1 -> CAPTURE.
REQ-018 CAPTURE SHALL write buffer[PATTERN_O] <= RESULT_I in exactly one cycle, then -> ADVANCE.
REQ-019 ADVANCE with PATTERN_O<15 SHALL increment PATTERN_O, clear settle counter, -> APPLY.
REQ-020 ADVANCE with PATTERN_O=15 SHALL increment SWEEP_COUNT_O (hold at 255), then MODE_I=1 -> PATTERN_O wraps to 0, -> APPLY; MODE_I=0 -> DONE, PATTERN_O held at 15.
REQ-021 Per-pattern latency SHALL be STEP_CYCLES+2 cycles; full sweep 16*(STEP_CYCLES+2) cycles from first APPLY cycle.
REQ-022 STOP_I=1 in APPLY/CAPTURE/ADVANCE SHALL force IDLE next cycle; no write that cycle; buffer and SWEEP_COUNT_O retained; PATTERN_O cleared to 0.
REQ-023 STOP_I and START_I edge in the same cycle: STOP_I wins, START edge discarded.
REQ-024 START_I edges while BUSY_O=1 SHALL be ignored.
REQ-025 READ_DATA_O SHALL be registered, 1-cycle latency, from any state; read of address written in same cycle returns prior contents.
REQ-026 DONE SHALL persist until START edge, STOP_I (-> IDLE), or reset.

Reset
REQ-027 resetn=0 at a clock edge SHALL force IDLE regardless of state, including mid-sweep.
REQ-028 Reset values: PATTERN_O=0, BUSY_O=0, DONE_O=0, SWEEP_COUNT_O=0, SIG_O=0, READ_DATA_O=0, settle counter=0, edge-detect register=0, all 16 buffer entries=0.
REQ-029 START_I held high through reset release SHALL NOT launch a sweep (edge register captures 0 during reset, first post-reset edge needs a low sample first).

Configuration
REQ-030 Macro SWEEP_SIGNATURE_EN defined: each CAPTURE SHALL update SIG_O <= {SIG_O[7:0],SIG_O[8]} ^ RESULT_I; SIG_O cleared to 0 on each sweep launch/wrap to pattern 0.
REQ-031 Macro SWEEP_SIGNATURE_EN undefined: SIG_O SHALL be constant 0, no signature logic synthesized; all other behaviour identical.

Verification
REQ-032 STEP_CYCLES=2, MODE_I=0, RESULT_I={5'b0,PATTERN_O}, START pulse -> BUSY_O high 64 cycles, then DONE_O=1, SWEEP_COUNT_O=1, READ_ADDR_I=k gives READ_DATA_O=k next cycle for k=0..15.
REQ-033 STEP_CYCLES=2, MODE_I=1, START pulse, run 200 cycles -> PATTERN_O 15->0 wrap without passing DONE, SWEEP_COUNT_O=3 at cycle 193.
REQ-034 Single sweep, STOP_I pulse during APPLY of pattern 6 -> IDLE next cycle, PATTERN_O=0, entries 0..5 written, entries 6..15 still 0.
REQ-035 resetn=0 for 1 cycle mid-sweep at pattern 9 -> all REQ-028 values next cycle, all buffer reads return 0; START_I held high across release does not launch.
REQ-036 START edge and STOP_I=1 same cycle from IDLE -> stays IDLE, BUSY_O=0; MODE_I=1 run of 300 sweeps -> SWEEP_COUNT_O saturates at 255.
REQ-037 SWEEP_SIGNATURE_EN defined, RESULT_I=9'h1FF constant, one sweep -> SIG_O matches rotate-XOR model over 16 captures; undefined -> SIG_O=0 throughout.
